// File: rtl/player_input_if.sv
// Button inputs and player-facing outputs of the player input front-end.
interface player_input_if;
   logic        btn_left;
   logic        btn_right;
   logic        btn_fire;
   logic [11:0] btn_col;
   logic [7:0]  btn_missle_en;
   logic        fire_pulse;

   modport master (
      output btn_left, btn_right, btn_fire,
      input  btn_col, btn_missle_en, fire_pulse
   );

   modport slave (
      input  btn_left, btn_right, btn_fire,
      output btn_col, btn_missle_en, fire_pulse
   );
endinterface

// File: rtl/player_input_ctrl.sv
// Player input front-end: 2-flop sync + debounce per button, ticked column stepping, round-robin fire toggles.
// Latency: raw edge -> debounced level 2+DEBOUNCE_CYCLES clks, debounced fire -> toggle 2 clks; no backpressure.
module player_input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 315000,
   parameter int MOVE_TICK       = 250000,
   parameter int STEP            = 2,
   parameter int COL_MIN         = 0,
   parameter int COL_MAX         = 609,
   parameter int COL_INIT        = 305,
   parameter int FIRE_COOLDOWN   = 8000000
) (
   input  logic           clk,
   input  logic           rst,
   player_input_if.slave  io
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TW = $clog2(MOVE_TICK + 1);
   localparam int CW = $clog2(FIRE_COOLDOWN + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FIRE,
      S_COOLDOWN,
      S_WAIT_RELEASE
   } fire_state_t;

   // Button index: 0 = left, 1 = right, 2 = fire
   logic [2:0]    sync_1;
   logic [2:0]    sync_2;
   logic [2:0]    level;
   logic [DW-1:0] db_cnt [3];

   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic [12:0]   col_inc;
   logic [12:0]   col_dec;
   logic [11:0]   next_col;

   fire_state_t   state;
   logic [2:0]    slot;
   logic [CW-1:0] cooldown;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_1 <= '0;
         sync_2 <= '0;
         level  <= '0;
         for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      end else begin
         sync_1 <= {io.btn_fire, io.btn_right, io.btn_left};
         sync_2 <= sync_1;
         for (int i = 0; i < 3; i++) begin
            if (sync_2[i] == level[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
               level[i]  <= ~level[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign tick    = (tick_cnt == TW'(MOVE_TICK - 1));
   assign col_inc = {1'b0, io.btn_col} + 13'(STEP);
   assign col_dec = {1'b0, io.btn_col} - 13'(STEP);

   // Saturate in 13 bits so a step below COL_MIN never wraps to a huge column.
   always_comb begin
      next_col = io.btn_col;
      if (level[0] && !level[1]) begin
         if ({1'b0, io.btn_col} < 13'(COL_MIN + STEP))
            next_col = 12'(COL_MIN);
         else
            next_col = col_dec[11:0];
      end else if (level[1] && !level[0]) begin
         if (col_inc > 13'(COL_MAX))
            next_col = 12'(COL_MAX);
         else
            next_col = col_inc[11:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt  <= '0;
         io.btn_col <= 12'(COL_INIT);
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
         if (tick) io.btn_col <= next_col;
      end
   end

   // fire_pulse is registered on entry to S_FIRE so it is high exactly in that state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= S_IDLE;
         slot             <= '0;
         cooldown         <= '0;
         io.btn_missle_en <= '0;
         io.fire_pulse    <= 1'b0;
      end else begin
         io.fire_pulse <= 1'b0;
         case (state)
            S_IDLE: begin
               if (level[2]) begin
                  state         <= S_FIRE;
                  io.fire_pulse <= 1'b1;
               end
            end
            S_FIRE: begin
               io.btn_missle_en[slot] <= ~io.btn_missle_en[slot];
               slot     <= slot + 3'd1;
               cooldown <= CW'(FIRE_COOLDOWN - 1);
               state    <= S_COOLDOWN;
            end
            S_COOLDOWN: begin
               if (cooldown == '0) state <= S_WAIT_RELEASE;
               else                cooldown <= cooldown - 1'b1;
            end
            S_WAIT_RELEASE: begin
               if (!level[2]) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_player_input_ctrl.sv
// Directed bench for player_input_ctrl with short debounce/tick/cooldown constants.
module tb_player_input_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;
   int   pulse_cnt = 0;
   int   snap;
   logic [8:0] mask;

   player_input_if io_if ();

   player_input_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .MOVE_TICK      (4),
      .STEP           (2),
      .COL_MIN        (0),
      .COL_MAX        (609),
      .COL_INIT       (305),
      .FIRE_COOLDOWN  (8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .io (io_if)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (io_if.fire_pulse) pulse_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
   endtask

   task automatic press(input int on_cyc, input int off_cyc);
      io_if.btn_fire = 1'b1;
      tick(on_cyc);
      io_if.btn_fire = 1'b0;
      tick(off_cyc);
   endtask

   initial begin
      rst = 1'b1;
      io_if.btn_left  = 1'b0;
      io_if.btn_right = 1'b0;
      io_if.btn_fire  = 1'b0;
      tick(2);
      check("rst_col",   32'(io_if.btn_col), 32'd305);
      check("rst_en",    32'(io_if.btn_missle_en), 32'h00);
      check("rst_pulse", 32'(io_if.fire_pulse), 32'd0);
      rst = 1'b0;
      tick(2);

      // Short glitch rejected, then a real press with exact timing
      press(3, 20);
      check("glitch_en", 32'(io_if.btn_missle_en), 32'h00);
      snap = pulse_cnt;
      io_if.btn_fire = 1'b1;
      tick(7);
      check("fire_state_pulse", 32'(io_if.fire_pulse), 32'd1);
      check("fire_state_en",    32'(io_if.btn_missle_en), 32'h00);
      tick(1);
      check("toggle_en",    32'(io_if.btn_missle_en), 32'h01);
      check("toggle_pulse", 32'(io_if.fire_pulse), 32'd0);
      tick(12);
      io_if.btn_fire = 1'b0;
      tick(20);
      check("one_pulse", 32'(pulse_cnt - snap), 32'd1);

      // Round-robin over all 8 slots, then reuse of slot 0
      do_reset();
      for (int i = 0; i < 8; i++) begin
         press(20, 20);
         mask = (9'd1 << (i + 1)) - 9'd1;
         check($sformatf("rr_%0d", i), 32'(io_if.btn_missle_en), 32'(mask[7:0]));
      end
      press(20, 20);
      check("rr_wrap", 32'(io_if.btn_missle_en), 32'hFE);

      // Movement right: first counted tick is 8 cycles after release of reset
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      io_if.btn_right = 1'b1;
      tick(20);
      check("right_20", 32'(io_if.btn_col), 32'd313);
      tick(4);
      check("right_24", 32'(io_if.btn_col), 32'd315);
      tick(584);
      check("right_608", 32'(io_if.btn_col), 32'd607);
      tick(4);
      check("right_612", 32'(io_if.btn_col), 32'd609);
      tick(88);
      check("right_sat", 32'(io_if.btn_col), 32'd609);

      rst = 1'b1;
      io_if.btn_right = 1'b0;
      tick(1);
      rst = 1'b0;
      io_if.btn_left = 1'b1;
      tick(20);
      check("left_20", 32'(io_if.btn_col), 32'd297);
      tick(592);
      check("left_612", 32'(io_if.btn_col), 32'd1);
      tick(4);
      check("left_616", 32'(io_if.btn_col), 32'd0);
      tick(84);
      check("left_sat", 32'(io_if.btn_col), 32'd0);

      rst = 1'b1;
      io_if.btn_left = 1'b0;
      tick(1);
      rst = 1'b0;
      io_if.btn_left  = 1'b1;
      io_if.btn_right = 1'b1;
      tick(40);
      check("both_hold", 32'(io_if.btn_col), 32'd305);
      io_if.btn_left  = 1'b0;
      io_if.btn_right = 1'b0;

      // Held fire never repeats; a re-press during cooldown is ignored
      do_reset();
      snap = pulse_cnt;
      io_if.btn_fire = 1'b1;
      tick(100);
      check("hold_en",    32'(io_if.btn_missle_en), 32'h01);
      check("hold_pulse", 32'(pulse_cnt - snap), 32'd1);
      io_if.btn_fire = 1'b0;
      tick(20);
      snap = pulse_cnt;
      press(5, 5);
      press(15, 20);
      check("cool_en",    32'(io_if.btn_missle_en), 32'h03);
      check("cool_pulse", 32'(pulse_cnt - snap), 32'd1);

      // Reset during cooldown restarts at slot 0
      do_reset();
      press(20, 20);
      io_if.btn_fire = 1'b1;
      tick(10);
      check("pre_rst_en", 32'(io_if.btn_missle_en), 32'h03);
      rst = 1'b1;
      io_if.btn_fire = 1'b0;
      tick(1);
      check("mid_rst_col",   32'(io_if.btn_col), 32'd305);
      check("mid_rst_en",    32'(io_if.btn_missle_en), 32'h00);
      check("mid_rst_pulse", 32'(io_if.fire_pulse), 32'd0);
      rst = 1'b0;
      tick(5);
      press(20, 20);
      check("post_rst_en", 32'(io_if.btn_missle_en), 32'h01);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
